// File: rtl/hint_bit_unpack.sv
// Hint-bit unpacker: walks the latched hint field one byte per cycle and
// rebuilds the K x N hint bitmap, rejecting any malformed encoding.
module hint_bit_unpack #(
    parameter int K     = 8,
    parameter int OMEGA = 75,
    parameter int N     = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(OMEGA+K)*8-1:0] y,
    output logic [K*N-1:0]         h,
    output logic                   valid,
    output logic                   done,
    output logic                   busy
);
    localparam int YW  = (OMEGA + K) * 8;
    localparam int YAW = $clog2(YW);
    localparam int HAW = $clog2(K * N);
    localparam int IW  = $clog2(OMEGA + 1) + 1;
    localparam int CW  = (IW > 8) ? IW : 8;
    localparam int KW  = (K > 1) ? $clog2(K) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CNT  = 3'd1;
    localparam logic [2:0] S_SET  = 3'd2;
    localparam logic [2:0] S_TAIL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]     r_state;
    logic [KW-1:0]  r_i;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  r_first;
    logic [YW-1:0]  r_y;
    logic [K*N-1:0] r_h;
    logic           r_valid;

    logic [7:0]     w_cur;
    logic [7:0]     w_prev;
    logic [7:0]     w_cnt_byte;
    logic [CW-1:0]  w_cnt;
    logic [CW-1:0]  w_idx;
    logic [CW-1:0]  w_idx_inc;
    logic [IW-1:0]  w_idx_nxt;
    logic [HAW-1:0] w_hpos;
    logic           w_last_poly;

    function automatic logic [7:0] f_byte(input logic [YW-1:0] v, input int j);
        return v[YAW'(j * 8) +: 8];
    endfunction

    always_comb begin
        w_cur       = f_byte(r_y, int'(r_idx));
        // idx-1 is only consumed when idx > first, so idx == 0 just needs a safe address
        w_prev      = f_byte(r_y, (r_idx == '0) ? 0 : int'(r_idx) - 1);
        w_cnt_byte  = f_byte(r_y, OMEGA + int'(r_i));
        w_cnt       = CW'(w_cnt_byte);
        w_idx       = CW'(r_idx);
        w_idx_nxt   = r_idx + IW'(1);
        w_idx_inc   = CW'(w_idx_nxt);
        w_hpos      = HAW'(32'(r_i) * 32'(N) + 32'(w_cur));
        w_last_poly = (r_i == KW'(K - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_idx   <= '0;
            r_first <= '0;
            r_y     <= '0;
            r_h     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_y     <= y;
                        r_h     <= '0;
                        r_valid <= 1'b0;
                        r_i     <= '0;
                        r_idx   <= '0;
                        r_first <= '0;
                        r_state <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (w_cnt < w_idx || w_cnt > CW'(OMEGA)) begin
                        r_h     <= '0;
                        r_valid <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_first <= r_idx;
                        if (w_idx < w_cnt) begin
                            r_state <= S_SET;
                        end else if (w_last_poly) begin
                            if (r_idx == IW'(OMEGA)) begin
                                r_valid <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_TAIL;
                            end
                        end else begin
                            r_i <= r_i + KW'(1);
                        end
                    end
                end
                S_SET: begin
                    if (r_idx > r_first && w_prev >= w_cur) begin
                        r_h     <= '0;
                        r_valid <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_h[w_hpos] <= 1'b1;
                        r_idx       <= w_idx_nxt;
                        if (w_idx_inc == w_cnt) begin
                            if (w_last_poly) begin
                                if (w_idx_nxt == IW'(OMEGA)) begin
                                    r_valid <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_state <= S_TAIL;
                                end
                            end else begin
                                r_i     <= r_i + KW'(1);
                                r_state <= S_CNT;
                            end
                        end
                    end
                end
                S_TAIL: begin
                    // Unused index slots must be zero padding
                    if (w_cur != 8'd0) begin
                        r_h     <= '0;
                        r_valid <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= w_idx_nxt;
                        if (w_idx_nxt == IW'(OMEGA)) begin
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign h     = r_h;
    assign valid = r_valid;
    assign done  = (r_state == S_DONE);
    assign busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_hint_bit_unpack.sv
// Scoreboard bench for hint_bit_unpack: stimulus pushes expected results,
// a monitor pops and compares them on every done pulse.
module tb_hint_bit_unpack;
    localparam int K     = 8;
    localparam int OMEGA = 75;
    localparam int N     = 256;
    localparam int YW    = (OMEGA + K) * 8;
    localparam int HW    = K * N;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [YW-1:0] y     = '0;
    logic [HW-1:0] h;
    logic          valid;
    logic          done;
    logic          busy;

    hint_bit_unpack #(.K(K), .OMEGA(OMEGA), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .y     (y),
        .h     (h),
        .valid (valid),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [HW-1:0] h;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int cyc       = 0;
    int start_cyc = 0;
    int n_cmp     = 0;
    int n_fail    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: actual done=1 required done=0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - start_cyc + 1, e.lat);
                    chk("valid", {31'd0, valid}, {31'd0, e.v});
                    n_cmp++;
                    if (h !== e.h) begin
                        n_fail++;
                        $display("FAIL h_vec: actual ones=%0d required ones=%0d differing bits=%0d",
                                 $countones(h), $countones(e.h), $countones(h ^ e.h));
                    end
                end
            end
        end
    end

    function automatic logic [YW-1:0] setb(input logic [YW-1:0] v, input int j, input int b);
        v[j*8 +: 8] = 8'(b);
        return v;
    endfunction

    function automatic logic [YW-1:0] counts(input logic [YW-1:0] v, input int c0, input int crest);
        v = setb(v, OMEGA, c0);
        for (int i = 1; i < K; i++) v = setb(v, OMEGA + i, crest);
        return v;
    endfunction

    task automatic issue(input logic [YW-1:0] yv);
        @(negedge clk);
        y         = yv;
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("valid_cleared", {31'd0, valid}, 32'd0);
    endtask

    task automatic run(input logic [YW-1:0] yv, input logic ev, input logic [HW-1:0] eh,
                       input int elat, input bit inject);
        exp_t e;
        e.v = ev; e.h = eh; e.lat = elat;
        sb.push_back(e);
        issue(yv);
        if (inject) begin
            repeat (5) @(negedge clk);
            y     = ~yv;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: actual no done required done within 300 cycles");
            sb.delete();
        end
        @(negedge clk);
    endtask

    logic [YW-1:0] yv;
    logic [YW-1:0] yasc;
    logic [HW-1:0] eh;
    bit            seen;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_h_ones", $countones(h), 0);
        chk("reset_valid", {31'd0, valid}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // all-zero field: empty hints, well-formed
        run('0, 1'b1, '0, 84, 1'b0);
        repeat (5) @(negedge clk);
        chk("valid_held", {31'd0, valid}, 1);

        // single hint h[0][5], plus a start pulse while busy that must be ignored
        yv = counts(setb('0, 0, 5), 1, 1);
        eh = '0; eh[5] = 1'b1;
        run(yv, 1'b1, eh, 84, 1'b1);

        // duplicate index within a polynomial
        yv = counts(setb(setb('0, 0, 7), 1, 7), 2, 2);
        run(yv, 1'b0, '0, 4, 1'b0);

        // first count exceeds OMEGA
        yv = setb('0, OMEGA, 76);
        run(yv, 1'b0, '0, 2, 1'b0);

        // nonzero padding byte in the tail
        yv = setb('0, 74, 1);
        run(yv, 1'b0, '0, 84, 1'b0);

        // full 75 hints, all in the last polynomial
        yasc = '0;
        for (int j = 0; j < OMEGA; j++) yasc = setb(yasc, j, j);
        yv = counts(yasc, 0, 0);
        yv = setb(yv, OMEGA + K - 1, 75);
        eh = '0;
        for (int c = 0; c < OMEGA; c++) eh[7*N + c] = 1'b1;
        run(yv, 1'b1, eh, 84, 1'b0);

        // full 75 hints, all in polynomial 0; later counts stay at OMEGA
        eh = '0;
        for (int c = 0; c < OMEGA; c++) eh[c] = 1'b1;
        run(counts(yasc, 75, 75), 1'b1, eh, 84, 1'b0);

        // hints spread over two polynomials
        yv = counts(setb(setb('0, 0, 3), 1, 9), 1, 2);
        eh = '0; eh[3] = 1'b1; eh[N + 9] = 1'b1;
        run(yv, 1'b1, eh, 84, 1'b0);

        // cumulative count decreases
        yv = setb(setb('0, 0, 1), 1, 2);
        yv = counts(yv, 2, 1);
        run(yv, 1'b0, '0, 5, 1'b0);

        // start arriving in the done cycle is ignored
        begin
            exp_t e;
            e.v = 1'b1; e.h = '0; e.lat = 84;
            sb.push_back(e);
        end
        issue('0);
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", {31'd0, seen}, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done_start", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        chk("still_idle", {31'd0, busy}, 0);
        sb.delete();

        // reset at cycle 40 aborts without a done pulse
        yv = counts(yasc, 0, 0);
        yv = setb(yv, OMEGA + K - 1, 75);
        issue(yv);
        for (int t = 0; t < 100 && (cyc - start_cyc + 1) < 40; t++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_h_ones", $countones(h), 0);
        chk("abort_valid", {31'd0, valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        eh = '0;
        for (int c = 0; c < OMEGA; c++) eh[7*N + c] = 1'b1;
        run(yv, 1'b1, eh, 84, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hint_bit_unpack.md
HINT_BIT_UNPACK -- requirements
Module: hint_bit_unpack

Interface
REQ-001 Parameter K, 8: number of hint polynomials.
REQ-002 Parameter OMEGA, 75: maximum total hint count.
REQ-003 Parameter N, 256: coefficients per polynomial.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  async active-high reset.
REQ-007 start  in  1  request pulse; sampled only in IDLE.
REQ-008 y  in  (OMEGA+K)*8  encoded hint field.
  - Byte j occupies bits [8j+7:8j].
  - Bytes 0..OMEGA-1 are hint indices; bytes OMEGA..OMEGA+K-1 are cumulative counts.
REQ-009 h  out  K*N  decoded hints; bit i*N+c is h[i][c].
REQ-010 valid  out  1  encoding well-formed; held until next start.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, CNT, SET, TAIL, DONE; registers: i (poly, 0..K-1), idx (0..OMEGA), first, y copy.
REQ-014 IDLE + start SHALL: latch y, clear h, valid, i, idx and first, then go to CNT.
REQ-015 start SHALL be ignored while busy=1; y is only read from the latched copy.
REQ-016 CNT (cnt = byte OMEGA+i) SHALL:
  - go to DONE with error if cnt < idx or cnt > OMEGA;
  - else set first=idx;
  - go to SET if idx < cnt;
  - else, if i == K-1, go to TAIL (or to DONE if idx == OMEGA);
  - else increment i and stay in CNT.
REQ-017 SET SHALL handle one index per cycle:
  - error if idx > first and byte[idx-1] >= byte[idx];
  - else set h[i][byte[idx]] and increment idx;
  - when the new idx == cnt, leave as in REQ-016 for the last-index case.
REQ-018 TAIL SHALL check one byte per cycle for idx..OMEGA-1:
  - a nonzero byte is an error;
  - after byte OMEGA-1, go to DONE.
REQ-019 Any error SHALL go to DONE on the next edge with the error flag set.
REQ-020 DONE SHALL:
  - assert done for exactly one cycle;
  - set valid = not error;
  - force h to all zero if error;
  - return to IDLE.
REQ-021 Latency for a well-formed input SHALL be exactly K+OMEGA cycles after the start edge, with done high in cycle K+OMEGA+1, independent of hint count.
REQ-022 Early error latency SHALL be (cycles consumed up to the failing check) + 1.
REQ-023 Index bytes SHALL be used as 8-bit unsigned values; values above N-1 cannot occur for N=256.
REQ-024 Count comparisons SHALL be unsigned, with width ceil(log2(OMEGA+1))+1 or wider.
REQ-025 Zero counts (empty polynomials) SHALL consume only their CNT cycle.
REQ-026 idx reaching OMEGA with i < K-1 is legal; remaining counts must equal OMEGA.
REQ-027 A start pulse arriving in the same cycle as done SHALL be ignored, because the FSM is not yet in IDLE.

Reset
REQ-028 rst SHALL immediately force IDLE, and zero h, valid, done, busy and all counters.
REQ-029 rst SHALL abort any operation in progress without producing a done pulse.

Verification
REQ-030 All-zero y, start -> done at cycle 84, valid=1, h=0.
REQ-031 y[0]=5, bytes 75..82 all =1, start -> valid=1, only h bit 5 (h[0][5]) set, done at cycle 84.
REQ-032 y[0]=7, y[1]=7, bytes 75..82 all =2 -> valid=0, h=0, done pulse.
REQ-033 byte 75 = 76 -> error in the first CNT cycle, done at cycle 2, valid=0.
REQ-034 y[74]=1, all counts 0 -> TAIL error, valid=0, h=0.
REQ-035 75 hints:
  - bytes 0..74 = 0..74;
  - bytes 75..81 = 0 and byte 82 = 75;
  - expected: valid=1, h[7][0..74] set, done at cycle 84;
  - repeat with rst asserted at cycle 40 -> outputs zero, no done pulse, next start behaves normally.
